// File: rtl/char_uart_pkg.sv
// Shared definitions for the character UART transmitter: FSM state encoding,
// frame geometry and a few ASCII constants.
package char_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

endpackage

// File: rtl/char_fifo.sv
// Circular character buffer between the producer handshake and the serialiser.
// A push into a full buffer is refused even when a pop happens in the same cycle.
module char_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/char_uart_tx.sv
// Buffers upper-cased characters and serialises them as 8N1 UART frames,
// LSB first, with gapless back-to-back frames and a completed-frame counter.
module char_uart_tx
    import char_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    logic [1:0]                state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]          frames_q, frames_d;
    logic                      tx_q, tx_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [7:0]                fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [OCC_W-1:0]          fifo_count;
    logic                      baud_last;

    // Ready depends only on reset and stored occupancy, never on in_valid.
    assign in_ready  = rst_n & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (in_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Serialiser: start bit, eight data bits, stop bit; chains straight into
    // the next frame when a character is waiting at the end of the stop bit.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        frames_d = frames_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_head;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        sh_d  = {1'b0, sh_q[UART_DATA_BITS-1:1]};
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d   = '0;
                    frames_d = frames_q + CNT_W'(1);
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_head;
                        bit_d    = '0;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx comes from a flop.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            frames_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
        end
    end

    assign tx          = tx_q;
    assign frames_sent = frames_q;
    assign busy        = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed bench for char_uart_tx: a frame-position model predicts every output
// each cycle, and literal expectations pin the model at key points.
module tb_char_uart_tx;
    import char_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic        in_ready, tx, busy;
    logic [15:0] frames_sent;
    logic        in_ready_w, tx_w, busy_w;
    logic [1:0]  frames_w;

    char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frames_sent(frames_sent)
    );

    char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .tx(tx_w), .busy(busy_w), .frames_sent(frames_w)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: pending characters, position within the current frame, frame count.
    logic [7:0] m_q[$];
    int         m_t      = -1;
    logic [7:0] m_cur    = 8'h00;
    int         m_frames = 0;
    bit         m_pushed = 1'b0;

    bit         rx_act  = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];

    bit         cap_en   = 1'b0;
    logic [1:0] cap_last = 2'd0;
    logic [1:0] cap_seq[$];

    logic       a_pat [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] hello [6]  = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21};
    logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_t      = -1;
        m_frames = 0;
        m_pushed = 1'b0;
    endtask

    task automatic rx_clear();
        rx_act = 1'b0;
        rx_cnt = 0;
    endtask

    function automatic logic exp_tx();
        int slot;
        if (m_t < 0) return 1'b1;
        slot = m_t / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    // One clock edge of the model: frames advance, a waiting character starts
    // a new frame, then an accepted character joins the queue.
    task automatic model_step();
        m_pushed = 1'b0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_pushed = in_valid && (m_q.size() != DEPTH);
        if (m_t >= 0) begin
            m_t++;
            if (m_t == FRAME) begin
                m_frames++;
                m_t = -1;
            end
        end
        if (m_t < 0 && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_t   = 0;
        end
        if (m_pushed) m_q.push_back(in_data);
    endtask

    task automatic check_all();
        logic exp_rdy;
        logic exp_busy;
        exp_rdy  = rst_n && (m_q.size() != DEPTH);
        exp_busy = (m_t >= 0) || (m_q.size() != 0);
        chk("in_ready",    32'(in_ready),    32'(exp_rdy));
        chk("in_ready_w",  32'(in_ready_w),  32'(exp_rdy));
        chk("tx",          32'(tx),          32'(exp_tx()));
        chk("tx_w",        32'(tx_w),        32'(exp_tx()));
        chk("busy",        32'(busy),        32'(exp_busy));
        chk("busy_w",      32'(busy_w),      32'(exp_busy));
        chk("frames_sent", 32'(frames_sent), 32'(m_frames % 65536));
        chk("frames_w",    32'(frames_w),    32'(m_frames % 4));
    endtask

    // Simple line receiver sampling mid-bit, to decode what the DUT sent.
    task automatic rx_step();
        if (!rst_n) begin
            rx_clear();
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end else if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                rx_byte[rx_cnt / CPB - 1] = tx;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
        rx_step();
        if (cap_en && frames_w !== cap_last) begin
            cap_seq.push_back(frames_w);
            cap_last = frames_w;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (m_pushed) break;
        end
        chk("push_accept", 32'(m_pushed), 32'd1);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain();
        for (int i = 0; i < 800; i++) begin
            if (m_t < 0 && m_q.size() == 0) break;
            tick();
        end
        chk("drain_idle", 32'(m_t < 0 && m_q.size() == 0), 32'd1);
        repeat (2) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        rx_clear();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;

        // Reset state
        #1 rst_n = 1'b0;
        model_clear();
        #2;
        chk("rst_tx",       32'(tx),          32'd1);
        chk("rst_in_ready", 32'(in_ready),    32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_frames",   32'(frames_sent), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle line
        repeat (100) tick();
        chk("idle_tx",       32'(tx),       32'd1);
        chk("idle_busy",     32'(busy),     32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Single 'A' frame
        rx_q.delete();
        push_byte(ASCII_A);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k == 0) chk("A_start_edge", 32'(tx), 32'd0);
            if ((k % CPB) == CPB / 2) chk($sformatf("A_slot%0d", k / CPB), 32'(tx), 32'(a_pat[k / CPB]));
        end
        tick();
        chk("A_busy_after", 32'(busy),        32'd0);
        chk("A_frames",     32'(frames_sent), 32'd1);
        chk("A_rx_count",   32'(rx_q.size()), 32'd1);
        if (rx_q.size() >= 1) chk("A_rx_byte", 32'(rx_q[0]), 32'h41);

        // Burst "HELLO!" with in_valid held high
        rx_q.delete();
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            push_byte(hello[i]);
            if (i == 0) c0 = cyc;
            if (i == 3) chk("burst_ready_after4", 32'(in_ready), 32'd1);
            if (i == 4) chk("burst_ready_after5", 32'(in_ready), 32'd0);
            if (i == 5) chk("full_pop_accept_cycle", 32'(cyc - c0), 32'd42);
        end
        drain();
        chk("burst_rx_count", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) chk($sformatf("burst_rx%0d", i), 32'(rx_q[i]), 32'(hello[i]));
        end
        chk("burst_frames", 32'(frames_sent), 32'd7);

        // Reset during data bit 3 of 'Z'
        push_byte(ASCII_Z);
        for (int i = 0; i < 200 && m_t != 4 * CPB + 1; i++) tick();
        chk("reach_bit3", 32'(m_t), 32'(4 * CPB + 1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx",       32'(tx),          32'd1);
        chk("midrst_busy",     32'(busy),        32'd0);
        chk("midrst_frames",   32'(frames_sent), 32'd0);
        chk("midrst_in_ready", 32'(in_ready),    32'd0);
        model_clear();
        rx_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_busy",     32'(busy),     32'd0);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        rx_q.delete();
        push_byte(ASCII_Z);
        drain();
        chk("postrst_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() >= 1) chk("postrst_rx_byte", 32'(rx_q[0]), 32'h5A);
        chk("postrst_frames", 32'(frames_sent), 32'd1);

        // Frame counter wrap on the 2-bit instance
        apply_reset();
        cap_seq.delete();
        cap_last = 2'd0;
        cap_en   = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
        drain();
        cap_en = 1'b0;
        chk("wrap_seq_len", 32'(cap_seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_seq.size()) chk($sformatf("wrap_seq%0d", i), 32'(cap_seq[i]), 32'(wrap_seq[i]));
        end
        chk("wrap_frames_wide", 32'(frames_sent), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
